// File: rtl/regfile_dumper.sv
// rtl/regfile_dumper.sv - streams the register file out as little-endian bytes over valid/ready
// Optional leading 0xA5 header byte when REGDUMP_HEADER_EN is defined.
module regfile_dumper #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [4:0]            o_raddr,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BW-1:0] LAST_BYTE = BW'(BYTES - 1);
    localparam logic [4:0]    LAST_REG  = 5'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_LOAD,
        S_SEND,
        S_DONE
    } state_t;

    state_t                state_q;
    logic [4:0]            reg_idx_q;
    logic [BW-1:0]         byte_idx_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  busy_q;
    logic                  done_q;
    logic [4:0]            raddr_q;
    logic                  valid_q;

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            reg_idx_q  <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            raddr_q    <= '0;
            valid_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        busy_q    <= 1'b1;
                        reg_idx_q <= '0;
                        raddr_q   <= '0;
`ifdef REGDUMP_HEADER_EN
                        // The header byte rides in the shift register so the tx path is shared.
                        shift_q   <= DATA_WIDTH'(8'hA5);
                        valid_q   <= 1'b1;
                        state_q   <= S_HEADER;
`else
                        state_q   <= S_LOAD;
`endif
                    end
                end
                S_HEADER: begin
                    if (i_tx_ready) begin
                        valid_q <= 1'b0;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    shift_q    <= i_rdata;
                    byte_idx_q <= '0;
                    valid_q    <= 1'b1;
                    state_q    <= S_SEND;
                end
                S_SEND: begin
                    if (i_tx_ready) begin
                        shift_q    <= shift_q >> 8;
                        byte_idx_q <= byte_idx_q + 1'b1;
                        if (byte_idx_q == LAST_BYTE) begin
                            valid_q <= 1'b0;
                            if (reg_idx_q < LAST_REG) begin
                                reg_idx_q <= reg_idx_q + 5'd1;
                                raddr_q   <= reg_idx_q + 5'd1;
                                state_q   <= S_LOAD;
                            end else begin
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    raddr_q <= '0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    raddr_q <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_raddr    = raddr_q;
    assign o_tx_valid = valid_q;
    assign o_tx_data  = shift_q[7:0];
endmodule

// File: tb/tb_regfile_dumper.sv
// tb/tb_regfile_dumper.sv - self-checking bench for regfile_dumper
module tb_regfile_dumper;
    localparam int DW    = 32;
    localparam int NR    = 32;
    localparam int BYTES = DW / 8;
`ifdef REGDUMP_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic          clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic          i_tx_ready = 1'b1;
    logic          o_busy, o_done, o_tx_valid;
    logic [4:0]    o_raddr;
    logic [7:0]    o_tx_data;
    logic [DW-1:0] i_rdata;
    logic [DW-1:0] regs [NR];

    always #5 clk = ~clk;

    regfile_dumper #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .clk        (clk),
        .i_rst_n    (i_rst_n),
        .i_start    (i_start),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_raddr    (o_raddr),
        .i_rdata    (i_rdata),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (i_tx_ready)
    );

    assign i_rdata = regs[o_raddr];

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic [7:0] got [$];
    logic [7:0] exp_q [$];
    int         done_cnt = 0;
    int         first_load = -1;
    int         first_valid = -1;
    int         last_xfer = -1;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    bit         rdy_mode = 1'b0;
    int         start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        i_tx_ready = rdy_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
    end

    // Transfer monitor: samples mid-cycle, records bytes, checks hold-under-stall.
    initial forever begin
        @(negedge clk);
        if (!i_rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(o_tx_valid), 32'd1);
                chk("hold_data", 32'(o_tx_data), 32'(prev_data));
            end
            if (o_tx_valid && i_tx_ready) begin
                got.push_back(o_tx_data);
                last_xfer = cyc;
            end
            if (o_tx_valid && first_valid < 0) first_valid = cyc;
            if (o_busy && !o_tx_valid && !o_done && first_load < 0) first_load = cyc;
            if (o_done) done_cnt++;
            prev_stall = o_tx_valid && !i_tx_ready;
            prev_data  = o_tx_data;
        end
    end

    task automatic start_pulse(input bit bp);
        got.delete();
        done_cnt    = 0;
        first_load  = -1;
        first_valid = -1;
        last_xfer   = -1;
        rdy_mode    = bp;
        @(posedge clk);
        #1;
        i_start   = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound && done_cnt == 0; i++) @(posedge clk);
        chk("done_seen", 32'(done_cnt != 0), 32'd1);
    endtask

    task automatic check_dump(input string tag, input bit bp);
        chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
        if (got.size() >= HDR + 8) begin
            chk({tag, "_r1b0"}, 32'(got[HDR+4]), 32'h01);
            chk({tag, "_r1b1"}, 32'(got[HDR+5]), 32'h00);
            chk({tag, "_r1b2"}, 32'(got[HDR+6]), 32'h01);
            chk({tag, "_r1b3"}, 32'(got[HDR+7]), 32'h01);
        end
        chk({tag, "_latency"}, 32'(first_valid - start_cyc), 32'(2 - HDR));
        if (!bp) chk({tag, "_span"}, 32'(last_xfer - first_load + 1), 32'(NR * (1 + BYTES)));
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        chk({tag, "_busy_after"}, 32'(o_busy), 32'd0);
        chk({tag, "_done_after"}, 32'(o_done), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_done"}, 32'(o_done), 32'd0);
        chk({tag, "_valid"}, 32'(o_tx_valid), 32'd0);
        chk({tag, "_raddr"}, 32'(o_raddr), 32'd0);
        chk({tag, "_data"}, 32'(o_tx_data), 32'd0);
    endtask

    initial begin
        for (int n = 0; n < NR; n++) regs[n] = DW'(32'h0101_0000 * n + n);
        if (HDR != 0) exp_q.push_back(8'hA5);
        for (int n = 0; n < NR; n++)
            for (int b = 0; b < BYTES; b++) exp_q.push_back(regs[n][8*b +: 8]);

        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        i_rst_n = 1'b1;

        start_pulse(1'b0);
        wait_done(2000);
        check_dump("full", 1'b0);

        start_pulse(1'b1);
        wait_done(8000);
        check_dump("bp", 1'b1);

        start_pulse(1'b0);
        for (int k = 0; k < 12; k++) begin
            repeat (9) @(posedge clk);
            #1;
            i_start = 1'b1;
            @(posedge clk);
            #1;
            i_start = 1'b0;
        end
        wait_done(2000);
        check_dump("restart_ign", 1'b0);
        repeat (15) @(posedge clk);
        #1;
        chk("restart_ign_single_done", 32'(done_cnt), 32'd1);

        start_pulse(1'b0);
        for (int i = 0; i < 2000 && got.size() < HDR + 7 * BYTES + 2; i++) begin
            @(posedge clk);
            #1;
        end
        chk("midrst_reached", 32'(got.size() >= HDR + 7 * BYTES + 2), 32'd1);
        i_rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_busy", 32'(o_busy), 32'd0);
        chk("midrst_valid", 32'(o_tx_valid), 32'd0);
        chk("midrst_done", 32'(o_done), 32'd0);
        i_rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_no_done", 32'(done_cnt), 32'd0);
        chk("midrst_idle", 32'(o_busy), 32'd0);

        start_pulse(1'b0);
        wait_done(2000);
        check_dump("after_rst", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_dumper.md
Name: regfile_dumper

Overview:
Debug-unit stage that reads the register file and streams its contents out as bytes. It drives one regfile read port through the address output and captures the combinational read data. Each register is serialized little-endian over a valid/ready byte interface, which feeds the UART transmitter. A dump is started by the debug controller, and the CPU is halted by that controller while the dump runs.

Parameters:
DATA_WIDTH, 32, width of each register. Must be a multiple of 8.
NUM_REGS, 32, number of registers dumped, starting at address 0. Range 1..32.

Ports:
clk  input  1  clock; all state changes on rising edge
i_rst_n  input  1  synchronous, active-low reset
i_start  input  1  dump request; sampled only in IDLE
o_busy  output  1  high in every state except IDLE
o_done  output  1  one-cycle pulse when the dump completes
o_raddr  output  5  read address to the regfile read port
i_rdata  input  DATA_WIDTH  regfile read data; combinational from o_raddr
o_tx_data  output  8  byte to the UART transmitter
o_tx_valid  output  1  o_tx_data is valid
i_tx_ready  input  1  transmitter accepts the byte this cycle

Behaviour:
- Reset (i_rst_n=0 at a clock edge):
  - Enters IDLE.
  - All outputs go to 0: o_busy, o_done, o_raddr, o_tx_data, o_tx_valid.
  - Reset overrides everything, including mid-dump. A partially sent dump is abandoned and no o_done is issued.
- IDLE:
  - o_tx_valid=0, o_raddr=0.
  - i_start=1 → go to LOAD, reg_idx=0.
- LOAD (1 cycle):
  - o_raddr=reg_idx.
  - At the clock edge, i_rdata is captured into a DATA_WIDTH shift register, byte_idx=0 → go to SEND.
- SEND:
  - o_tx_valid=1, o_tx_data = shift register bits [7:0].
  - A byte transfers on a cycle where o_tx_valid && i_tx_ready.
  - On transfer: shift register shifts right by 8 and byte_idx increments.
  - While i_tx_ready=0, o_tx_data and o_tx_valid are held stable with no shifting.
  - Transfer of byte DATA_WIDTH/8-1:
    - reg_idx < NUM_REGS-1 → increment reg_idx, go to LOAD.
    - Otherwise → go to DONE.
- DONE (1 cycle): o_done=1, o_tx_valid=0 → go to IDLE.
- Byte order: register 0 first, each register least-significant byte first.
  - x0 is dumped as whatever the regfile returns, which is 0.
- i_start while busy is ignored, with no queuing. i_start held high through DONE starts a new dump on the first IDLE cycle.
- Throughput with i_tx_ready tied high:
  - 1 LOAD cycle plus DATA_WIDTH/8 SEND cycles per register.
  - Defaults: 5 cycles/register, 160 cycles from first LOAD to last transfer, then 1 DONE cycle.
- Latency: i_start sampled at edge t → LOAD during cycle t+1 → first o_tx_valid during cycle t+2.
- o_raddr changes only at LOAD entry, so i_rdata is stable when captured.
- The regfile read is sampled in LOAD only. Register writes during SEND do not affect the byte in flight.

Optional Feature:
Macro REGDUMP_HEADER_EN.
- Defined: a HEADER state is inserted between IDLE and the first LOAD.
  - HEADER sends byte 0xA5 with the same valid/ready rules, then goes to LOAD.
  - First o_tx_valid moves to cycle t+1 and carries 0xA5.
  - Total bytes = NUM_REGS*DATA_WIDTH/8 + 1 (129 at defaults).
- Undefined: no HEADER state. The stream starts directly with register 0, 128 bytes at defaults.

Test Plan:
- Reset check: i_rst_n=0 for 2 cycles → o_busy=0, o_done=0, o_tx_valid=0, o_raddr=0, o_tx_data=0.
- Full dump, ready tied high:
  - Stimulus: regfile xN=32'h0101_0000*N + N, then a 1-cycle i_start pulse.
  - Required: 128 bytes, register 0 first, LSB first.
  - Register 1 bytes are 01,00,01,01.
  - Last transfer is 160 cycles after the first LOAD, o_done exactly 1 cycle, o_busy=0 afterwards.
- Backpressure:
  - Stimulus: i_tx_ready pseudo-random (~30% high).
  - Required: byte sequence identical to the no-backpressure dump.
  - o_tx_data stays constant in every cycle where o_tx_valid=1 and i_tx_ready=0.
- i_start pulsed repeatedly mid-dump → exactly one dump of 128 bytes and one o_done pulse.
- Reset mid-operation:
  - Stimulus: i_rst_n=0 during register 7, byte 2.
  - Required: IDLE on the next cycle, o_tx_valid=0, no o_done.
  - A new i_start restarts from register 0, byte 0.
- REGDUMP_HEADER_EN defined → first transferred byte is 8'hA5, then the same 128 bytes, 129 transfers total.
